// File: rtl/duck_sprite_scheduler_pkg.sv
// Shared types for the duck sprite layer: scheduler FSM states,
// screen coordinate type and the default transparent colour key.
package duck_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      FETCH,
      RESOLVE,
      DONE
   } sched_state_t;

   typedef logic [9:0] coord_t;

   localparam logic [11:0] KEY_RGB_DEFAULT = 12'hAEA;

endpackage

// File: rtl/duck_sprite_scheduler_if.sv
// Sprite ROM + palette bus shared with other layers.
// master: drives rom_addr/pal_index; slave: returns rom_index/pal_rgb.
interface duck_sprite_scheduler_if #(
   parameter int unsigned ADDR_W = 10
);
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        rom_index;
   logic [3:0]        pal_index;
   logic [11:0]       pal_rgb;

   modport master (
      output rom_addr,
      output pal_index,
      input  rom_index,
      input  pal_rgb
   );

   modport slave (
      input  rom_addr,
      input  pal_index,
      output rom_index,
      output pal_rgb
   );
endinterface

// File: rtl/duck_sprite_scheduler_hit_test.sv
// Combinational hit test of one sprite slot against a pixel.
// In: px,py pixel; x,y sprite top-left; active. Out: hit, ROM offset.
module duck_hit_test
   import duck_pkg::*;
#(
   parameter int unsigned SPR_W  = 32,
   parameter int unsigned SPR_H  = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  coord_t            px,
   input  coord_t            py,
   input  coord_t            x,
   input  coord_t            y,
   input  logic              active,
   output logic              hit,
   output logic [ADDR_W-1:0] offset
);

   logic [10:0] dx;
   logic [10:0] dy;
   logic [31:0] dx_w;
   logic [31:0] dy_w;

   // 11-bit difference: bit 10 flags a pixel left/above the sprite,
   // so a 10-bit wrap never turns into a false hit.
   assign dx   = {1'b0, px} - {1'b0, x};
   assign dy   = {1'b0, py} - {1'b0, y};
   assign dx_w = 32'(dx);
   assign dy_w = 32'(dy);

   assign hit = active && !dx[10] && !dy[10]
             && (dx_w < SPR_W) && (dy_w < SPR_H);

   assign offset = ADDR_W'(dy_w * SPR_W + dx_w);

endmodule

// File: rtl/duck_sprite_scheduler.sv
// Per-pixel duck sprite scheduler: scans slots in priority order,
// fetches ROM index, resolves palette, first non-key colour wins.
// Ports: Clk/Reset, pix_start+DrawX/DrawY request, per-slot duck_x/
// duck_y/duck_active, mem (ROM/palette bus), pix_* result, busy, overrun.
module duck_sprite_scheduler
   import duck_pkg::*;
#(
   parameter int unsigned NUM_DUCKS = 4,
   parameter int unsigned SPR_W     = 32,
   parameter int unsigned SPR_H     = 32,
   parameter int unsigned ADDR_W    = 10,
   parameter logic [11:0] KEY_RGB   = KEY_RGB_DEFAULT
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    pix_start,
   input  coord_t                  DrawX,
   input  coord_t                  DrawY,
   input  logic [NUM_DUCKS*10-1:0] duck_x,
   input  logic [NUM_DUCKS*10-1:0] duck_y,
   input  logic [NUM_DUCKS-1:0]    duck_active,
   duck_sprite_scheduler_if.master mem,
   output logic                    pix_valid,
   output logic                    pix_hit,
   output logic [2:0]              pix_slot,
   output logic [3:0]              red,
   output logic [3:0]              green,
   output logic [3:0]              blue,
   output logic                    busy,
   output logic                    overrun
);

   sched_state_t            state;
   logic [2:0]              k;
   coord_t                  px;
   coord_t                  py;
   logic [ADDR_W-1:0]       rom_addr_q;
   logic                    hit;
   logic [ADDR_W-1:0]       hit_off;
   logic [NUM_DUCKS*10-1:0] sx;
   logic [NUM_DUCKS*10-1:0] sy;
   logic [NUM_DUCKS-1:0]    sa;
   coord_t                  cur_x;
   coord_t                  cur_y;
   logic                    cur_act;
   logic                    last;

   // Slot k's fields, selected by shifting the packed slot vectors.
   always_comb begin
      sx      = duck_x >> (10 * int'(k));
      sy      = duck_y >> (10 * int'(k));
      sa      = duck_active >> k;
      cur_x   = sx[9:0];
      cur_y   = sy[9:0];
      cur_act = sa[0];
   end

   assign last = (32'(k) == NUM_DUCKS - 1);

   duck_hit_test #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ADDR_W (ADDR_W)
   ) u_hit (
      .px     (px),
      .py     (py),
      .x      (cur_x),
      .y      (cur_y),
      .active (cur_act),
      .hit    (hit),
      .offset (hit_off)
   );

   assign mem.rom_addr  = rom_addr_q;
   assign mem.pal_index = (state == RESOLVE) ? mem.rom_index : 4'd0;
   assign busy          = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         k          <= '0;
         px         <= '0;
         py         <= '0;
         rom_addr_q <= '0;
         pix_valid  <= 1'b0;
         pix_hit    <= 1'b0;
         pix_slot   <= '0;
         red        <= '0;
         green      <= '0;
         blue       <= '0;
         overrun    <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         if (pix_start && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (pix_start) begin
                  px    <= DrawX;
                  py    <= DrawY;
                  k     <= '0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (hit) begin
                  rom_addr_q <= hit_off;
                  state      <= FETCH;
               end else if (last) begin
                  pix_hit   <= 1'b0;
                  pix_slot  <= '0;
                  red       <= '0;
                  green     <= '0;
                  blue      <= '0;
                  pix_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k <= k + 3'd1;
               end
            end
            FETCH: state <= RESOLVE;
            RESOLVE: begin
               if (mem.pal_rgb != KEY_RGB) begin
                  red       <= mem.pal_rgb[11:8];
                  green     <= mem.pal_rgb[7:4];
                  blue      <= mem.pal_rgb[3:0];
                  pix_hit   <= 1'b1;
                  pix_slot  <= k;
                  pix_valid <= 1'b1;
                  state     <= DONE;
               end else if (last) begin
                  pix_hit   <= 1'b0;
                  pix_slot  <= '0;
                  red       <= '0;
                  green     <= '0;
                  blue      <= '0;
                  pix_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k     <= k + 3'd1;
                  state <= CHECK;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
